// File: rtl/dooz_pkg.sv
// Shared types for the dooz display path: winner codes, matrix size and scan states.
// Also holds the debug view of the sequencer FSM and the row-select helper.
package dooz_pkg;

    localparam int MAT_DIM = 8;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    // Internal sequencer state exported for observation.
    typedef struct packed {
        scan_state_t state;
        logic [2:0]  idx;
        logic        pending;
        logic        blink_on;
    } seq_dbg_t;

    function automatic logic [MAT_DIM-1:0] row_onehot(input logic [2:0] idx);
        return MAT_DIM'(1) << idx;
    endfunction

endpackage

// File: rtl/beep_timer.sv
// Retriggerable pulse stretcher: beep goes high the cycle after a trigger and
// stays high for BEEP_CYC cycles; a new trigger restarts the count.
module beep_timer #(
    parameter int BEEP_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic beep
);

    localparam int CW = $clog2(BEEP_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            beep <= 1'b0;
        end else if (trigger) begin
            cnt  <= CW'(BEEP_CYC);
            beep <= 1'b1;
        end else begin
            if (cnt != '0)
                cnt <= cnt - CW'(1);
            // cnt holds the remaining cycles including the one being entered
            beep <= (cnt > CW'(1));
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Row-multiplexed 8x8 LED matrix driver with double-buffered frame loading,
// winner blink and beep trigger generation.
module display_sequencer
    import dooz_pkg::*;
#(
    parameter int DWELL        = 1000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 32,
    parameter int BEEP_CYC     = 500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAT_DIM*MAT_DIM-1:0] mat,
    input  logic                     mat_valid,
    input  logic [1:0]               winner,
    input  logic                     beep_req,
    output logic                     mat_ack,
    output logic [MAT_DIM-1:0]       row,
    output logic [MAT_DIM-1:0]       col,
    output logic [3:0]               leds,
    output logic                     beep,
    output logic                     frame_done,
    output seq_dbg_t                 dbg
);

    localparam int CW = $clog2((DWELL > BLANK) ? DWELL : BLANK) + 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    // Handshake: mat is taken on any edge with mat_valid=1 and mat_ack=0;
    // mat_ack is high for exactly the next cycle, which masks a held mat_valid.

    scan_state_t                state;
    logic [CW-1:0]              cnt;
    logic [2:0]                 idx;
    logic [MAT_DIM*MAT_DIM-1:0] disp;
    logic [MAT_DIM*MAT_DIM-1:0] shadow;
    logic                       pending;
    logic                       blink_on;
    logic [BW-1:0]              blink_cnt;
    logic [1:0]                 win_q;

    logic          last_scan;
    logic          last_blank;
    logic          frame_edge;
    logic          capture;
    logic          pending_nxt;
    logic          blink_on_nxt;
    logic [BW-1:0] blink_cnt_nxt;
    logic          beep_trig;

    always_comb begin
        last_scan  = (state == ST_SCAN)  && (cnt == CW'(DWELL - 1));
        last_blank = (state == ST_BLANK) && (cnt == CW'(BLANK - 1));
        frame_edge = last_blank && (idx == 3'd7);
        capture    = mat_valid && !mat_ack;

        // A capture on the frame edge wins, so the new frame waits a full frame.
        pending_nxt = pending;
        if (frame_edge)
            pending_nxt = 1'b0;
        if (capture)
            pending_nxt = 1'b1;

        blink_on_nxt  = blink_on;
        blink_cnt_nxt = blink_cnt;
        if (winner == WIN_NONE) begin
            blink_on_nxt  = 1'b1;
            blink_cnt_nxt = '0;
        end else if (frame_edge) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_on_nxt  = ~blink_on;
                blink_cnt_nxt = '0;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end

        beep_trig = beep_req || ((win_q == WIN_NONE) && (winner != WIN_NONE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_SCAN;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            blink_on   <= 1'b1;
            blink_cnt  <= '0;
            win_q      <= WIN_NONE;
            mat_ack    <= 1'b0;
            row        <= '0;
            col        <= '1;
            leds       <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (last_scan) begin
                        state <= ST_BLANK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (last_blank) begin
                        state <= ST_SCAN;
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        if (frame_edge && pending)
                            disp <= shadow;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_SCAN;
                    cnt   <= '0;
                end
            endcase

            if (capture)
                shadow <= mat;
            mat_ack   <= capture;
            pending   <= pending_nxt;
            blink_on  <= blink_on_nxt;
            blink_cnt <= blink_cnt_nxt;
            win_q     <= winner;

            // Outputs reflect the state being left, so each row holds DWELL cycles.
            row <= (state == ST_SCAN) ? row_onehot(idx) : '0;
            col <= (state == ST_SCAN && blink_on) ? ~disp[{idx, 3'b000} +: MAT_DIM] : '1;
            leds       <= {blink_on_nxt, pending_nxt, winner};
            frame_done <= frame_edge;
        end
    end

    assign dbg.state    = state;
    assign dbg.idx      = idx;
    assign dbg.pending  = pending;
    assign dbg.blink_on = blink_on;

    beep_timer #(
        .BEEP_CYC (BEEP_CYC)
    ) u_beep (
        .clk     (clk),
        .rst     (rst),
        .trigger (beep_trig),
        .beep    (beep)
    );

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter DWELL, default 1000: clock cycles each row is driven.
REQ-002 Parameter BLANK, default 16: clock cycles of all-off blanking after each row.
REQ-003 Parameter BLINK_FRAMES, default 32: frames per blink phase while a winner is shown.
REQ-004 Parameter BEEP_CYC, default 500000: beep pulse length in cycles.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 mat  in  64  frame from control unit; bit r*8+c is row r, column c, 1 = lit.
REQ-008 mat_valid  in  1  frame load request, held until mat_ack.
REQ-009 winner  in  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-010 beep_req  in  1  one-cycle beep trigger.
REQ-011 mat_ack  out  1  one-cycle capture acknowledge.
REQ-012 row  out  8  one-hot active-high row select.
REQ-013 col  out  8  active-low column data for the selected row.
REQ-014 leds  out  4  status: [1:0] winner, [2] pending, [3] blink phase.
REQ-015 beep  out  1  buzzer enable, active-high.
REQ-016 frame_done  out  1  one-cycle pulse per completed frame.

Function
REQ-017 The sequencer SHALL cycle through states SCAN (DWELL cycles, row driven) and BLANK (BLANK cycles, row=0, col=8'hFF), then advance the row index.
REQ-018 The row index SHALL run 0..7 and wrap to 0; one frame = 8*(DWELL+BLANK) cycles.
REQ-019 In SCAN, row SHALL be one-hot of the index and col SHALL be ~disp[idx*8 +: 8]; all outputs SHALL be registered.
REQ-020 mat SHALL be captured into a shadow register on the edge where mat_valid=1 and mat_ack=0; mat_ack SHALL be 1 for exactly the following cycle and pending SHALL be set.
REQ-021 mat_valid still high during the mat_ack cycle SHALL NOT cause a second capture.
REQ-022 On the last BLANK cycle of row 7 (frame boundary), if pending=1 the display buffer SHALL load the shadow value held before that edge and pending SHALL clear.
REQ-023 A capture on the frame-boundary edge SHALL leave pending=1; that new frame SHALL be displayed from the next boundary.
REQ-024 frame_done SHALL be 1 for the cycle after the frame-boundary edge.
REQ-025 With winner=00, the blink phase SHALL be 1 (on) and the blink frame counter SHALL be held at 0.
REQ-026 With winner!=00, the blink phase SHALL toggle every BLINK_FRAMES frames, starting on; in the off phase col SHALL be 8'hFF while row still scans.
REQ-027 beep_req=1, or a winner transition from 00 to nonzero, SHALL set beep=1 for BEEP_CYC cycles starting the next cycle; a retrigger while active SHALL restart the count.
REQ-028 A winner change between nonzero values SHALL NOT retrigger beep.

Reset
REQ-029 While rst=0: row=0, col=8'hFF, mat_ack=0, beep=0, frame_done=0, leds=0.
REQ-030 While rst=0: row index 0, state SCAN, all counters 0, display and shadow buffers 0, pending=0, blink phase 1.
REQ-031 Reset asserted mid-frame SHALL abort scanning immediately; after release, scanning SHALL restart at row 0 with a full DWELL.

Structure
REQ-032 Shared package dooz_pkg SHALL hold the winner codes, matrix dimension constant (8), and the SCAN/BLANK state enum.
REQ-033 The beep pulse generator SHALL be a sub-module beep_timer (trigger in, BEEP_CYC parameter, beep out); all other logic SHALL be in display_sequencer.

Verification (DWELL=4, BLANK=1, BLINK_FRAMES=2, BEEP_CYC=10)
REQ-034 Release reset, mat=0 -> row sequence 01,00,02,00,...,80,00 with 4 driven and 1 blank cycle each; frame_done pulses every 40 cycles.
REQ-035 mat=64'h0000_0000_0000_00A5 with mat_valid -> mat_ack for one cycle; from the next boundary, row 01 shows col=8'h5A and other rows show 8'hFF.
REQ-036 mat_valid held 3 cycles -> exactly one mat_ack and one capture; a capture on the boundary edge is displayed one frame later.
REQ-037 winner 00->01 -> beep high for 10 cycles; leds[1:0]=01; col forced to 8'hFF during frames 3-4, 7-8, ...; winner 01->10 produces no beep.
REQ-038 beep_req at cycle 5 of an active beep -> beep stays high 10 cycles after the retrigger.
REQ-039 rst low during row 5 SCAN -> all outputs at reset values asynchronously; after release, row=01 for 4 cycles and the display buffer is 0.
